fft_stage_sequencer: RTL and testbench

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_delay_line.sv | 28 ++
 rtl/fft_stage_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT stage sequencer.
// FSM state encoding, stage counter width and LOG2N bounds.
package fft_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } fft_state_e;

  localparam int STAGE_W   = 4;
  localparam int LOG2N_MIN = 3;
  localparam int LOG2N_MAX = 12;

endpackage

// File: rtl/fft_delay_line.sv
// Enable-gated shift register of configurable width and depth.
// Carries read-side address/valid to the write-back side.
module fft_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  // Shift one slot per enabled cycle; reset drops pending entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 in-place FFT address/stage sequencer with ping-pong banks.
// Optional inverse support when FFT_SEQ_INVERSE_EN is defined.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N  = 10,
  parameter int WR_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               hold_i,
`ifdef FFT_SEQ_INVERSE_EN
  input  logic               inverse_i,
  output logic               tw_conj_o,
  output logic               scale_o,
`endif
  output logic [LOG2N-1:0]   address_a_o,
  output logic [LOG2N-1:0]   address_b_o,
  output logic               rd_en_o,
  output logic [LOG2N-1:0]   wr_address_a_o,
  output logic [LOG2N-1:0]   wr_address_b_o,
  output logic               wr_en_o,
  output logic [LOG2N-2:0]   twiddle_idx_o,
  output logic               memsel_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int AW = LOG2N;
  localparam int KW = LOG2N - 1;
  localparam int TW = LOG2N - 1;
  localparam int DW = 1 + 2 * AW;

  localparam logic [KW-1:0]      K_LAST   = '1;
  localparam logic [3:0]         LAT_LAST = 4'(WR_LAT - 1);
  localparam logic [STAGE_W-1:0] ST_LAST  = STAGE_W'(LOG2N - 1);

  fft_state_e         state;
  logic [STAGE_W-1:0] stage;
  logic [KW-1:0]      k;
  logic [3:0]         dcnt;
  logic               memsel;
  logic               busy_q;
  logic               done_q;
  logic               rd_q;
  logic [AW-1:0]      a_q;
  logic [AW-1:0]      b_q;
  logic [TW-1:0]      tw_q;

  logic [STAGE_W-1:0] iss_s;
  logic [KW-1:0]      iss_k;
  logic [AW-1:0]      nxt_a;
  logic [AW-1:0]      nxt_b;
  logic [TW-1:0]      nxt_tw;

  logic               act;
  logic [DW-1:0]      dl_d;
  logic [DW-1:0]      dl_q;

  function automatic logic [AW-1:0] f_span(
    input logic [STAGE_W-1:0] s
  );
    return AW'(1) << s;
  endfunction

  function automatic logic [AW-1:0] f_addr_a(
    input logic [STAGE_W-1:0] s,
    input logic [KW-1:0]      kv
  );
    logic [AW-1:0] kk;
    logic [AW-1:0] m;
    kk = AW'(kv);
    m  = f_span(s) - AW'(1);
    return ((kk >> s) << (s + 1'b1)) | (kk & m);
  endfunction

  function automatic logic [TW-1:0] f_tw(
    input logic [STAGE_W-1:0] s,
    input logic [KW-1:0]      kv
  );
    logic [AW-1:0] kk;
    logic [AW-1:0] m;
    logic [AW-1:0] t;
    kk = AW'(kv);
    m  = f_span(s) - AW'(1);
    t  = (kk & m) << (ST_LAST - s);
    return t[TW-1:0];
  endfunction

  assign act = ~hold_i;

  // Butterfly to be issued next cycle: first of run, first of stage, or k+1.
  always_comb begin
    iss_s = stage;
    iss_k = k + 1'b1;
    unique case (state)
      S_IDLE: begin
        iss_s = '0;
        iss_k = '0;
      end
      S_NEXT: begin
        iss_s = stage + 1'b1;
        iss_k = '0;
      end
      default: ;
    endcase
    nxt_a  = f_addr_a(iss_s, iss_k);
    nxt_b  = nxt_a + f_span(iss_s);
    nxt_tw = f_tw(iss_s, iss_k);
  end

  // Sequencer FSM with registered read-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      stage  <= '0;
      k      <= '0;
      dcnt   <= '0;
      memsel <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tw_q   <= '0;
    end else if (act) begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            state  <= S_RUN;
            stage  <= '0;
            k      <= '0;
            memsel <= 1'b0;
            busy_q <= 1'b1;
            rd_q   <= 1'b1;
            a_q    <= nxt_a;
            b_q    <= nxt_b;
            tw_q   <= nxt_tw;
          end
        end
        S_RUN: begin
          if (k == K_LAST) begin
            state <= S_DRAIN;
            rd_q  <= 1'b0;
            dcnt  <= '0;
          end else begin
            k    <= iss_k;
            rd_q <= 1'b1;
            a_q  <= nxt_a;
            b_q  <= nxt_b;
            tw_q <= nxt_tw;
          end
        end
        S_DRAIN: begin
          if (dcnt == LAT_LAST) state <= S_NEXT;
          else dcnt <= dcnt + 1'b1;
        end
        S_NEXT: begin
          memsel <= ~memsel;
          if (stage == ST_LAST) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state <= S_RUN;
            stage <= iss_s;
            k     <= '0;
            rd_q  <= 1'b1;
            a_q   <= nxt_a;
            b_q   <= nxt_b;
            tw_q  <= nxt_tw;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dl_d = {rd_q, a_q, b_q};

  fft_delay_line #(
    .W     (DW),
    .DEPTH (WR_LAT)
  ) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .en  (act),
    .d   (dl_d),
    .q   (dl_q)
  );

  assign address_a_o    = a_q;
  assign address_b_o    = b_q;
  assign twiddle_idx_o  = tw_q;
  assign rd_en_o        = rd_q & act;
  assign wr_address_a_o = dl_q[2*AW-1:AW];
  assign wr_address_b_o = dl_q[AW-1:0];
  assign wr_en_o        = dl_q[DW-1] & act;
  assign memsel_o       = memsel;
  assign stage_o        = stage;
  assign busy_o         = busy_q;
  assign done_o         = done_q & act;

`ifdef FFT_SEQ_INVERSE_EN
  logic inv_q;

  // Direction is captured once per run at start acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (act && state == S_IDLE && start_i) begin
      inv_q <= inverse_i;
    end
  end

  assign tw_conj_o = inv_q;
  assign scale_o   = wr_en_o & inv_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer at LOG2N=3, WR_LAT=2.
// Expected read/write/done events are queued; a monitor checks them.
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       hold_i;
  logic [2:0] address_a_o;
  logic [2:0] address_b_o;
  logic       rd_en_o;
  logic [2:0] wr_address_a_o;
  logic [2:0] wr_address_b_o;
  logic       wr_en_o;
  logic [1:0] twiddle_idx_o;
  logic       memsel_o;
  logic [3:0] stage_o;
  logic       busy_o;
  logic       done_o;
`ifdef FFT_SEQ_INVERSE_EN
  logic       inverse_i;
  logic       tw_conj_o;
  logic       scale_o;
`endif

  fft_stage_sequencer #(
    .LOG2N  (3),
    .WR_LAT (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .hold_i         (hold_i),
`ifdef FFT_SEQ_INVERSE_EN
    .inverse_i      (inverse_i),
    .tw_conj_o      (tw_conj_o),
    .scale_o        (scale_o),
`endif
    .address_a_o    (address_a_o),
    .address_b_o    (address_b_o),
    .rd_en_o        (rd_en_o),
    .wr_address_a_o (wr_address_a_o),
    .wr_address_b_o (wr_address_b_o),
    .wr_en_o        (wr_en_o),
    .twiddle_idx_o  (twiddle_idx_o),
    .memsel_o       (memsel_o),
    .stage_o        (stage_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int a; int b; int tw; int st; int ms;
  } rd_t;
  typedef struct {
    int cyc; int a; int b;
  } wr_t;
  typedef struct {
    int cyc; int ms;
  } dn_t;

  rd_t rdq[$];
  wr_t wrq[$];
  dn_t dnq[$];
  rd_t er;
  wr_t ew;
  dn_t ed;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Hand-computed butterfly schedule for N=8.
  int ra[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int rb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int rt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int ro[12] = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d want %0d", n, cyc, act, exp);
    end
  endfunction

  function automatic int shf(int o, int hfrom);
    return (hfrom >= 0 && o >= hfrom) ? o + 3 : o;
  endfunction

  // Queue the expected events of one run started in cycle base.
  function automatic void push_run(int base, int hfrom, int cutoff);
    rd_t r;
    wr_t w;
    dn_t d;
    for (int i = 0; i < 12; i++) begin
      r.cyc = shf(ro[i], hfrom);
      r.a = ra[i];
      r.b = rb[i];
      r.tw = rt[i];
      r.st = i / 4;
      r.ms = (i / 4) % 2;
      if (r.cyc < cutoff) begin
        r.cyc += base;
        rdq.push_back(r);
      end
    end
    for (int i = 0; i < 12; i++) begin
      w.cyc = shf(ro[i] + 2, hfrom);
      w.a = ra[i];
      w.b = rb[i];
      if (w.cyc < cutoff) begin
        w.cyc += base;
        wrq.push_back(w);
      end
    end
    d.cyc = shf(22, hfrom);
    d.ms = 1;
    if (d.cyc < cutoff) begin
      d.cyc += base;
      dnq.push_back(d);
    end
  endfunction

  // Monitor: pop and compare whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      while (rdq.size() > 0 && rdq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL rd_missing: cycle %0d no read, want one at %0d",
                 cyc, rdq[0].cyc);
        void'(rdq.pop_front());
      end
      if (rd_en_o) begin
        checks++;
        if (rdq.size() == 0 || rdq[0].cyc != cyc) begin
          errors++;
          $display("FAIL rd_unexpected: cycle %0d got read (%0d,%0d)",
                   cyc, address_a_o, address_b_o);
        end else begin
          er = rdq.pop_front();
          if (int'(address_a_o) != er.a || int'(address_b_o) != er.b ||
              int'(twiddle_idx_o) != er.tw || int'(stage_o) != er.st ||
              int'(memsel_o) != er.ms) begin
            errors++;
            $display("FAIL rd_data: cycle %0d got a=%0d b=%0d tw=%0d st=%0d ms=%0d want a=%0d b=%0d tw=%0d st=%0d ms=%0d",
                     cyc, address_a_o, address_b_o, twiddle_idx_o,
                     stage_o, memsel_o, er.a, er.b, er.tw, er.st, er.ms);
          end
        end
      end
      while (wrq.size() > 0 && wrq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL wr_missing: cycle %0d no write, want one at %0d",
                 cyc, wrq[0].cyc);
        void'(wrq.pop_front());
      end
      if (wr_en_o) begin
        checks++;
        if (wrq.size() == 0 || wrq[0].cyc != cyc) begin
          errors++;
          $display("FAIL wr_unexpected: cycle %0d got write (%0d,%0d)",
                   cyc, wr_address_a_o, wr_address_b_o);
        end else begin
          ew = wrq.pop_front();
          if (int'(wr_address_a_o) != ew.a ||
              int'(wr_address_b_o) != ew.b) begin
            errors++;
            $display("FAIL wr_data: cycle %0d got (%0d,%0d) want (%0d,%0d)",
                     cyc, wr_address_a_o, wr_address_b_o, ew.a, ew.b);
          end
        end
`ifdef FFT_SEQ_INVERSE_EN
        check("scale_mirror", int'(scale_o), int'(tw_conj_o));
`endif
      end
      while (dnq.size() > 0 && dnq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL done_missing: cycle %0d no done, want one at %0d",
                 cyc, dnq[0].cyc);
        void'(dnq.pop_front());
      end
      if (done_o) begin
        checks++;
        if (dnq.size() == 0 || dnq[0].cyc != cyc) begin
          errors++;
          $display("FAIL done_unexpected: cycle %0d got done", cyc);
        end else begin
          ed = dnq.pop_front();
          if (int'(memsel_o) != ed.ms || int'(stage_o) != 2 ||
              busy_o !== 1'b1) begin
            errors++;
            $display("FAIL done_data: cycle %0d got ms=%0d st=%0d busy=%0d want ms=%0d st=2 busy=1",
                     cyc, memsel_o, stage_o, busy_o, ed.ms);
          end
        end
      end
    end
  end

  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base;
  int b2;

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    hold_i = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
    inverse_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", int'(rd_en_o), 0);
    check("rst_wr_en", int'(wr_en_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_addr_a", int'(address_a_o), 0);
    check("rst_wr_addr_b", int'(wr_address_b_o), 0);
    check("rst_memsel", int'(memsel_o), 0);
    check("rst_stage", int'(stage_o), 0);
    rst = 1'b0;
    wait_to(cyc + 1);

    // Plain run.
    base = cyc;
    start_i = 1'b1;
    push_run(base, -1, 1000);
    wait_to(base + 1);
    start_i = 1'b0;
    check("run_busy", int'(busy_o), 1);
    wait_to(base + 23);
    check("run_busy_end", int'(busy_o), 0);
    wait_to(base + 26);

    // Hold during cycles 2-4 shifts everything later by 3.
    base = cyc;
    start_i = 1'b1;
    push_run(base, 2, 1000);
    wait_to(base + 1);
    start_i = 1'b0;
    wait_to(base + 2);
    hold_i = 1'b1;
    #1;
    check("hold_rd_en", int'(rd_en_o), 0);
    check("hold_addr_a", int'(address_a_o), 2);
    wait_to(base + 5);
    hold_i = 1'b0;
    wait_to(base + 26);
    check("hold_busy_end", int'(busy_o), 0);
    wait_to(base + 29);

    // Hold over the start cycle delays acceptance.
    base = cyc;
    start_i = 1'b1;
    hold_i = 1'b1;
    wait_to(base + 2);
    check("hold_start_busy", int'(busy_o), 0);
    hold_i = 1'b0;
    push_run(base + 2, -1, 1000);
    wait_to(base + 3);
    start_i = 1'b0;
    wait_to(base + 27);

    // Reset mid-stage discards pending writes, then restart.
    base = cyc;
    start_i = 1'b1;
    push_run(base, -1, 9);
    wait_to(base + 1);
    start_i = 1'b0;
    wait_to(base + 9);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", int'(rd_en_o), 0);
    check("mid_rst_wr_en", int'(wr_en_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_stage", int'(stage_o), 0);
    check("mid_rst_memsel", int'(memsel_o), 0);
    check("mid_rst_addr_b", int'(address_b_o), 0);
    check("mid_rst_twiddle", int'(twiddle_idx_o), 0);
    wait_to(base + 10);
    rst = 1'b0;
    wait_to(base + 12);
    b2 = cyc;
    start_i = 1'b1;
    push_run(b2, -1, 1000);
    wait_to(b2 + 1);
    start_i = 1'b0;
    check("restart_memsel", int'(memsel_o), 0);
    check("restart_stage", int'(stage_o), 0);
    wait_to(b2 + 25);

    // start_i held high: one run, next accepted right after DONE.
    base = cyc;
    start_i = 1'b1;
    push_run(base, -1, 1000);
    push_run(base + 23, -1, 1000);
    wait_to(base + 24);
    start_i = 1'b0;
    wait_to(base + 47);
    check("held_start_idle", int'(busy_o), 0);
    wait_to(base + 52);
    check("held_start_no_third", int'(busy_o), 0);

`ifdef FFT_SEQ_INVERSE_EN
    // Inverse latched at start; later changes are ignored.
    base = cyc;
    start_i = 1'b1;
    inverse_i = 1'b1;
    push_run(base, -1, 1000);
    wait_to(base + 1);
    start_i = 1'b0;
    check("inv_conj_start", int'(tw_conj_o), 1);
    wait_to(base + 5);
    inverse_i = 1'b0;
    wait_to(base + 12);
    check("inv_conj_mid", int'(tw_conj_o), 1);
    check("inv_scale_mid", int'(scale_o), int'(wr_en_o));
    wait_to(base + 26);
`endif

    wait_to(cyc + 3);
    check("rd_queue_empty", rdq.size(), 0);
    check("wr_queue_empty", wrq.size(), 0);
    check("done_queue_empty", dnq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
